console_cmd_issuer: RTL and testbench

Upstream feeder of the console/LCD editor block. Converts debounced keypad codes into one-cycle console commands: insert symbol, delete, move cursor, change mode. Buffers keys in a small FIFO and issues one command at a time under the console's available handshake. Tracks cursor position and program length so illegal edits never reach the display.

---
 rtl/console_cmd_issuer_if.sv | 34 +++
 rtl/console_cmd_issuer.sv | 167 ++++++++++++++++
 tb/tb_console_cmd_issuer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/console_cmd_issuer_if.sv
// Signal bundle between the keypad-side command issuer and the console/LCD editor.
// The master modport is the issuer; the slave modport is the keypad/console side.
interface console_cmd_issuer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       exec_busy;
    logic       available;
    logic       to_mode;
    logic       change_mode;
    logic [3:0] symbol_to_insert;
    logic       insert;
    logic       delete;
    logic       cursor_dir;
    logic       move_cursor;
    logic       please_wait;
    logic [6:0] cursor_pos;
    logic [6:0] prog_len;
    logic       reject;
    logic       fifo_full;

    modport master (
        input  key_valid, key_code, exec_busy, available,
        output to_mode, change_mode, symbol_to_insert, insert, delete,
               cursor_dir, move_cursor, please_wait, cursor_pos, prog_len,
               reject, fifo_full
    );

    modport slave (
        output key_valid, key_code, exec_busy, available,
        input  to_mode, change_mode, symbol_to_insert, insert, delete,
               cursor_dir, move_cursor, please_wait, cursor_pos, prog_len,
               reject, fifo_full
    );
endinterface

// File: rtl/console_cmd_issuer.sv
// Keypad-to-console command issuer: buffers mapped key codes, checks each popped
// command against mode / cursor / length, and issues one-cycle command pulses
// under the console's available handshake.
module console_cmd_issuer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PROG_MAX    = 64,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 working_clock,
    input  logic                 resetn,
    console_cmd_issuer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [3:0]         cmd_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [6:0]         cursor_reg, len_reg;
    logic               mode_reg, please_wait_reg;
    logic [3:0]         symbol_reg;
    logic               dir_reg, to_mode_reg;

    // Codes 0x9, 0xE and 0xF have no command and are never buffered.
    logic key_mapped, push, pop, fifo_full;
    assign key_mapped = (bus.key_code <= 4'h8) || ((bus.key_code >= 4'hA) && (bus.key_code <= 4'hD));
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign push       = bus.key_valid && key_mapped && !fifo_full;
    assign pop        = (state_reg == IDLE) && (count_reg != '0) && bus.available;

    // Decode of the command currently being checked / issued.
    logic is_ins, is_del, is_left, is_right, is_tog, edit_blocked, legal;
    assign is_ins   = (cmd_reg <= 4'h8);
    assign is_del   = (cmd_reg == 4'hA);
    assign is_left  = (cmd_reg == 4'hB);
    assign is_right = (cmd_reg == 4'hC);
    assign is_tog   = (cmd_reg == 4'hD);
    assign edit_blocked = mode_reg || please_wait_reg;

    // Legality: toggle always passes; edits need edit mode, an idle interpreter and room.
    always_comb begin
        legal = 1'b0;
        if (is_tog)
            legal = 1'b1;
        else if (is_ins)
            legal = !edit_blocked && (len_reg != 7'(PROG_MAX));
        else if (is_del || is_left)
            legal = !edit_blocked && (cursor_reg != 7'd0);
        else if (is_right)
            legal = !edit_blocked && (cursor_reg != len_reg);
    end

    // Key storage and registered read of the head entry on pop.
    always_ff @(posedge working_clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.key_code;
        if (pop)
            cmd_reg <= fifo_mem[rd_ptr_reg];
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge working_clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge working_clock or negedge resetn) begin
        if (!resetn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; an unanswered command is treated as instantaneous after the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (pop) state_next = CHECK;
            CHECK:     state_next = legal ? ISSUE : IDLE;
            ISSUE:     state_next = WAIT_ACK;
            WAIT_ACK:  if (!bus.available)
                           state_next = WAIT_DONE;
                       else if (timer_reg == TMR_W'(ACK_TIMEOUT - 1))
                           state_next = IDLE;
            WAIT_DONE: if (bus.available) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Handshake timer, held data outputs, and tracking registers updated at the end of ISSUE.
    always_ff @(posedge working_clock or negedge resetn) begin
        if (!resetn) begin
            timer_reg       <= '0;
            cursor_reg      <= '0;
            len_reg         <= '0;
            mode_reg        <= 1'b0;
            please_wait_reg <= 1'b0;
            symbol_reg      <= '0;
            dir_reg         <= 1'b0;
            to_mode_reg     <= 1'b0;
        end else begin
            please_wait_reg <= bus.exec_busy;
            if (state_reg == WAIT_ACK)
                timer_reg <= timer_reg + TMR_W'(1);
            else
                timer_reg <= '0;
            if ((state_reg == CHECK) && legal) begin
                if (is_ins)
                    symbol_reg <= (cmd_reg == 4'h8) ? 4'h9 : cmd_reg;
                if (is_left || is_right)
                    dir_reg <= is_right;
                if (is_tog)
                    to_mode_reg <= ~mode_reg;
            end
            if (state_reg == ISSUE) begin
                if (is_ins) begin
                    cursor_reg <= cursor_reg + 7'd1;
                    len_reg    <= len_reg + 7'd1;
                end else if (is_del) begin
                    cursor_reg <= cursor_reg - 7'd1;
                    len_reg    <= len_reg - 7'd1;
                end else if (is_left) begin
                    cursor_reg <= cursor_reg - 7'd1;
                end else if (is_right) begin
                    cursor_reg <= cursor_reg + 7'd1;
                end else if (is_tog) begin
                    mode_reg <= ~mode_reg;
                end
            end
        end
    end

    // Output decode: command pulses in ISSUE, reject in CHECK, held data from registers.
    always_comb begin
        bus.insert           = (state_reg == ISSUE) && is_ins;
        bus.delete           = (state_reg == ISSUE) && is_del;
        bus.move_cursor      = (state_reg == ISSUE) && (is_left || is_right);
        bus.change_mode      = (state_reg == ISSUE) && is_tog;
        bus.reject           = (state_reg == CHECK) && !legal;
        bus.symbol_to_insert = symbol_reg;
        bus.cursor_dir       = dir_reg;
        bus.to_mode          = to_mode_reg;
        bus.please_wait      = please_wait_reg;
        bus.cursor_pos       = cursor_reg;
        bus.prog_len         = len_reg;
        bus.fifo_full        = fifo_full;
    end
endmodule

// File: tb/tb_console_cmd_issuer.sv
// Bench for console_cmd_issuer: vector table plus hand-written multi-cycle sequences,
// with a scoreboard of expected command pulses checked by a negedge monitor.
module tb_console_cmd_issuer;
    localparam int K_INS = 0, K_DEL = 1, K_MOV = 2, K_CHG = 3, K_REJ = 4, K_NONE = 7;

    typedef struct {
        logic [3:0] key;
        logic       busy;
        int         kind;
        logic [3:0] data;
        logic [6:0] cur;
        logic [6:0] len;
    } vec_t;

    typedef struct {
        int         kind;
        logic [3:0] data;
        logic [6:0] cur;
        logic [6:0] len;
    } exp_t;

    logic clk;
    logic resetn;
    console_cmd_issuer_if bus();

    console_cmd_issuer dut (
        .working_clock(clk),
        .resetn       (resetn),
        .bus          (bus)
    );

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pulse_count = 0;
    int   last_pulse_cyc = 0;
    int   prev_pulse_cyc = 0;
    int   key_cyc = 0;
    bit   track_pending = 0;
    exp_t track_exp;
    bit   console_auto = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] data, input logic [6:0] cur, input logic [6:0] len);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cur  = cur;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    task automatic send_key(input logic [3:0] k);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        key_cyc       = cyc;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int i;
        i = 0;
        while ((sb_q.size() != 0 || track_pending) && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (i >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d expected commands still outstanding after %0d cycles, required 0", name, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulses"}, int'({bus.insert, bus.delete, bus.move_cursor, bus.change_mode, bus.reject}), 0);
        check({tag, "_symbol"}, int'(bus.symbol_to_insert), 0);
        check({tag, "_dir_mode"}, int'({bus.cursor_dir, bus.to_mode}), 0);
        check({tag, "_please_wait"}, int'(bus.please_wait), 0);
        check({tag, "_fifo_full"}, int'(bus.fifo_full), 0);
        check({tag, "_cursor_pos"}, int'(bus.cursor_pos), 0);
        check({tag, "_prog_len"}, int'(bus.prog_len), 0);
    endtask

    // Monitor: every command/reject pulse is matched against the scoreboard head;
    // tracking outputs are compared on the following cycle.
    initial forever begin
        int   n;
        int   kind;
        int   data;
        exp_t e;
        @(negedge clk);
        if (!resetn) begin
            track_pending = 0;
        end else begin
            if (track_pending) begin
                check("cursor_pos", int'(bus.cursor_pos), int'(track_exp.cur));
                check("prog_len", int'(bus.prog_len), int'(track_exp.len));
                track_pending = 0;
            end
            n = int'(bus.insert) + int'(bus.delete) + int'(bus.move_cursor) + int'(bus.change_mode) + int'(bus.reject);
            if (n != 0) begin
                pulse_count++;
                prev_pulse_cyc = last_pulse_cyc;
                last_pulse_cyc = cyc;
                kind = K_REJ;
                data = 0;
                if (bus.insert) begin
                    kind = K_INS; data = int'(bus.symbol_to_insert);
                end else if (bus.delete) begin
                    kind = K_DEL;
                end else if (bus.move_cursor) begin
                    kind = K_MOV; data = int'(bus.cursor_dir);
                end else if (bus.change_mode) begin
                    kind = K_CHG; data = int'(bus.to_mode);
                end
                $display("cycle %0d: command kind %0d data %0d (cursor_pos %0d prog_len %0d before update)",
                         cyc, kind, data, bus.cursor_pos, bus.prog_len);
                check("pulses_per_cycle", n, 1);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got kind %0d data %0d, required no command", kind, data);
                end else begin
                    e = sb_q.pop_front();
                    check("cmd_kind", kind, e.kind);
                    check("cmd_data", data, int'(e.data));
                    track_exp     = e;
                    track_pending = 1;
                end
            end
        end
    end

    // Console model: when enabled, lowers available one cycle after a command for 3 cycles.
    initial forever begin
        @(negedge clk);
        if (console_auto && resetn && (bus.insert || bus.delete || bus.move_cursor || bus.change_mode)) begin
            @(posedge clk);
            #1 bus.available = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.available = 1'b1;
        end
    end

    vec_t vecs[19];

    function automatic vec_t mk(input logic [3:0] key, input logic busy, input int kind,
                                input logic [3:0] data, input logic [6:0] cur, input logic [6:0] len);
        vec_t v;
        v.key = key; v.busy = busy; v.kind = kind; v.data = data; v.cur = cur; v.len = len;
        return v;
    endfunction

    initial begin
        int pc0;
        int k0;

        // Empty program: every edit is rejected; then editing, mode toggles and busy interlock.
        vecs[0]  = mk(4'hA, 0, K_REJ,  4'h0, 7'd0, 7'd0);
        vecs[1]  = mk(4'hB, 0, K_REJ,  4'h0, 7'd0, 7'd0);
        vecs[2]  = mk(4'hC, 0, K_REJ,  4'h0, 7'd0, 7'd0);
        vecs[3]  = mk(4'h8, 0, K_INS,  4'h9, 7'd1, 7'd1);
        vecs[4]  = mk(4'hB, 0, K_MOV,  4'h0, 7'd0, 7'd1);
        vecs[5]  = mk(4'hC, 0, K_MOV,  4'h1, 7'd1, 7'd1);
        vecs[6]  = mk(4'hC, 0, K_REJ,  4'h0, 7'd1, 7'd1);
        vecs[7]  = mk(4'hD, 0, K_CHG,  4'h1, 7'd1, 7'd1);
        vecs[8]  = mk(4'h2, 0, K_REJ,  4'h0, 7'd1, 7'd1);
        vecs[9]  = mk(4'hA, 0, K_REJ,  4'h0, 7'd1, 7'd1);
        vecs[10] = mk(4'hD, 0, K_CHG,  4'h0, 7'd1, 7'd1);
        vecs[11] = mk(4'h2, 0, K_INS,  4'h2, 7'd2, 7'd2);
        vecs[12] = mk(4'hB, 0, K_MOV,  4'h0, 7'd1, 7'd2);
        vecs[13] = mk(4'h5, 0, K_INS,  4'h5, 7'd2, 7'd3);
        vecs[14] = mk(4'hA, 0, K_DEL,  4'h0, 7'd1, 7'd2);
        vecs[15] = mk(4'hE, 0, K_NONE, 4'h0, 7'd1, 7'd2);
        vecs[16] = mk(4'h3, 1, K_REJ,  4'h0, 7'd1, 7'd2);
        vecs[17] = mk(4'hD, 1, K_CHG,  4'h1, 7'd1, 7'd2);
        vecs[18] = mk(4'hD, 1, K_CHG,  4'h0, 7'd1, 7'd2);

        resetn        = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.exec_busy = 1'b0;
        bus.available = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Latency and handshake: insert 0x3 then delete, console lowers available after each.
        console_auto  = 1;
        bus.available = 1'b1;
        repeat (2) @(posedge clk);
        expect_ev(K_INS, 4'h3, 7'd1, 7'd1);
        send_key(4'h3);
        k0 = key_cyc;
        expect_ev(K_DEL, 4'h0, 7'd0, 7'd0);
        send_key(4'hA);
        drain(100, "latency_drain");
        check("insert_latency", prev_pulse_cyc - k0, 3);
        check("wait_for_available", last_pulse_cyc - prev_pulse_cyc, 7);
        repeat (6) @(posedge clk);

        // Table-driven single-key vectors.
        for (int i = 0; i < 19; i++) begin
            if (bus.exec_busy != vecs[i].busy) begin
                @(posedge clk);
                #1 bus.exec_busy = vecs[i].busy;
                repeat (2) @(posedge clk);
                #1;
                check("please_wait", int'(bus.please_wait), int'(vecs[i].busy));
            end
            pc0 = pulse_count;
            if (vecs[i].kind != K_NONE)
                expect_ev(vecs[i].kind, vecs[i].data, vecs[i].cur, vecs[i].len);
            send_key(vecs[i].key);
            drain(100, "vector_drain");
            repeat (6) @(posedge clk);
            if (vecs[i].kind == K_NONE)
                check("discarded_key", pulse_count - pc0, 0);
        end
        @(posedge clk);
        #1 bus.exec_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Move right back to the end: cursor 2, length 2.
        expect_ev(K_MOV, 4'h1, 7'd2, 7'd2);
        send_key(4'hC);
        drain(100, "vector_drain");
        repeat (6) @(posedge clk);

        // Console held busy: 4 keys buffered, 5th dropped, then issued in order.
        console_auto = 0;
        @(posedge clk);
        #1 bus.available = 1'b0;
        repeat (3) @(posedge clk);
        pc0 = pulse_count;
        expect_ev(K_INS, 4'h1, 7'd3, 7'd3);
        expect_ev(K_INS, 4'h2, 7'd4, 7'd4);
        expect_ev(K_INS, 4'h3, 7'd5, 7'd5);
        expect_ev(K_INS, 4'h4, 7'd6, 7'd6);
        send_key(4'h1);
        send_key(4'h2);
        send_key(4'h3);
        check("fifo_full_at_3", int'(bus.fifo_full), 0);
        send_key(4'h4);
        check("fifo_full_at_4", int'(bus.fifo_full), 1);
        send_key(4'h5);
        check("fifo_full_after_drop", int'(bus.fifo_full), 1);
        repeat (10) @(posedge clk);
        check("held_no_issue", pulse_count - pc0, 0);
        console_auto = 1;
        bus.available = 1'b1;
        drain(300, "release_drain");
        repeat (6) @(posedge clk);
        check("issued_after_release", pulse_count - pc0, 4);
        check("fifo_empty_after_release", int'(bus.fifo_full), 0);

        // Console never acknowledges: the issuer times out and issues the next command.
        console_auto = 0;
        expect_ev(K_MOV, 4'h0, 7'd5, 7'd6);
        expect_ev(K_MOV, 4'h1, 7'd6, 7'd6);
        send_key(4'hB);
        send_key(4'hC);
        drain(200, "timeout_drain");
        check("timeout_gap", last_pulse_cyc - prev_pulse_cyc, 18);
        repeat (20) @(posedge clk);

        // Reset with keys pending and non-zero state.
        @(posedge clk);
        #1;
        bus.available = 1'b0;
        bus.exec_busy = 1'b1;
        send_key(4'h0);
        send_key(4'h1);
        send_key(4'h2);
        send_key(4'h3);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_full", int'(bus.fifo_full), 1);
        check("pre_reset_please_wait", int'(bus.please_wait), 1);
        check("pre_reset_symbol", int'(bus.symbol_to_insert), 4);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        resetn        = 1'b1;
        bus.exec_busy = 1'b0;
        bus.available = 1'b1;
        pc0 = pulse_count;
        repeat (15) @(posedge clk);
        #1;
        check("no_issue_after_reset", pulse_count - pc0, 0);
        check("post_reset_fifo_full", int'(bus.fifo_full), 0);
        check("post_reset_prog_len", int'(bus.prog_len), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
